// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - L1 icache/dcache arbiter for the single L2 port (optional ARB_RR_EN: round-robin ties)
`timescale 1ns/1ps
module l2_req_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_rw,
    input  logic              ic_complete,
    input  logic              drq,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_rw,
    input  logic [DATA_W-1:0] dc_wd,
    input  logic              dc_complete,
    input  logic              l2_busy,
    input  logic              l2_rdy,
    input  logic [DATA_W-1:0] l2_rd,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rw,
    output logic [DATA_W-1:0] l2_wd,
    output logic              ic_gnt,
    output logic              dc_gnt,
    output logic              ic_busy,
    output logic              dc_busy,
    output logic              ic_rdy,
    output logic              dc_rdy,
    output logic [DATA_W-1:0] ic_rd,
    output logic [DATA_W-1:0] dc_rd
);

    // Command encoding shared with both L1 caches and the L2 controller
    localparam logic RW_READ = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_IC  = 3'd1,
        GNT_DC  = 3'd2,
        FILL_IC = 3'd3,
        FILL_DC = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                l2_req_q, l2_req_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
    logic                l2_rw_q, l2_rw_d;
    logic [DATA_W-1:0]   l2_wd_q, l2_wd_d;
    logic                ic_gnt_q, ic_gnt_d;
    logic                dc_gnt_q, dc_gnt_d;
    logic                ic_rdy_q, ic_rdy_d;
    logic                dc_rdy_q, dc_rdy_d;
    logic [DATA_W-1:0]   ic_rd_q, ic_rd_d;
    logic [DATA_W-1:0]   dc_rd_q, dc_rd_d;
    logic                pick_dc;

`ifdef ARB_RR_EN
    // 0 = icache was granted last, 1 = dcache was granted last
    logic                last_gnt_q, last_gnt_d;

    // Round-robin: on a tie the requester not granted last wins
    always_comb begin
        pick_dc = drq && (!irq || !last_gnt_q);
    end
`else
    // Fixed priority: the dcache wins every tie
    always_comb begin
        pick_dc = drq;
    end
`endif

    // Next-state and next-output computation for the grant FSM
    always_comb begin
        state_d   = state_q;
        l2_addr_d = l2_addr_q;
        l2_rw_d   = l2_rw_q;
        l2_wd_d   = l2_wd_q;
        ic_rd_d   = ic_rd_q;
        dc_rd_d   = dc_rd_q;
        ic_rdy_d  = 1'b0;
        dc_rdy_d  = 1'b0;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!l2_busy && (irq || drq)) begin
                    if (pick_dc) begin
                        state_d   = GNT_DC;
                        l2_addr_d = dc_addr;
                        l2_rw_d   = dc_rw;
                        l2_wd_d   = dc_wd;
`ifdef ARB_RR_EN
                        last_gnt_d = 1'b1;
`endif
                    end else begin
                        state_d   = GNT_IC;
                        l2_addr_d = ic_addr;
                        l2_rw_d   = ic_rw;
                        l2_wd_d   = '0;
`ifdef ARB_RR_EN
                        last_gnt_d = 1'b0;
`endif
                    end
                end
            end
            GNT_IC: begin
                if (l2_rdy) begin
                    ic_rdy_d = 1'b1;
                    if (l2_rw_q == RW_READ) begin
                        ic_rd_d = l2_rd;
                        state_d = FILL_IC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GNT_DC: begin
                if (l2_rdy) begin
                    dc_rdy_d = 1'b1;
                    if (l2_rw_q == RW_READ) begin
                        dc_rd_d = l2_rd;
                        state_d = FILL_DC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FILL_IC: begin
                if (ic_complete) begin
                    state_d = IDLE;
                end
            end
            FILL_DC: begin
                if (dc_complete) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Request and grant flops follow the next state so they line up with it
        l2_req_d = (state_d == GNT_IC) || (state_d == GNT_DC);
        ic_gnt_d = (state_d == GNT_IC) || (state_d == FILL_IC);
        dc_gnt_d = (state_d == GNT_DC) || (state_d == FILL_DC);
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            l2_rw_q   <= 1'b0;
            l2_wd_q   <= '0;
            ic_gnt_q  <= 1'b0;
            dc_gnt_q  <= 1'b0;
            ic_rdy_q  <= 1'b0;
            dc_rdy_q  <= 1'b0;
            ic_rd_q   <= '0;
            dc_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            l2_req_q  <= l2_req_d;
            l2_addr_q <= l2_addr_d;
            l2_rw_q   <= l2_rw_d;
            l2_wd_q   <= l2_wd_d;
            ic_gnt_q  <= ic_gnt_d;
            dc_gnt_q  <= dc_gnt_d;
            ic_rdy_q  <= ic_rdy_d;
            dc_rdy_q  <= dc_rdy_d;
            ic_rd_q   <= ic_rd_d;
            dc_rd_q   <= dc_rd_d;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant history; starts as icache so the first tie goes to the dcache
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign l2_req  = l2_req_q;
    assign l2_addr = l2_addr_q;
    assign l2_rw   = l2_rw_q;
    assign l2_wd   = l2_wd_q;
    assign ic_gnt  = ic_gnt_q;
    assign dc_gnt  = dc_gnt_q;
    assign ic_rdy  = ic_rdy_q;
    assign dc_rdy  = dc_rdy_q;
    assign ic_rd   = ic_rd_q;
    assign dc_rd   = dc_rd_q;

    // Busy is combinational so a requester sees L2 backpressure in the same cycle
    assign ic_busy = (state_q != IDLE) ? !ic_gnt_q : l2_busy;
    assign dc_busy = (state_q != IDLE) ? !dc_gnt_q : l2_busy;

endmodule
